// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing check.
// Optional macro UART_RX_PARITY_EN adds a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_byte_rx #(
  parameter int BIT_PERIOD  = 10417,
  parameter int HALF_PERIOD = BIT_PERIOD / 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        framing_error,
  output logic        parity_error,
  output logic [15:0] led_debug
);

  localparam int CW = $clog2(BIT_PERIOD + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state_q, state_d;
  logic          sync_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
  logic          busy_q, busy_d;
  logic [3:0]    state_led;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    par_bad_d  = par_bad_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d   = START;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rx_s_q != ((^shift_q) ^ PARITY_ODD));
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // A low stop bit wins over a parity mismatch; only a clean frame updates rx_data.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            state_d    = IDLE;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == START) || (state_d == DATA) ||
             (state_d == PARITY) || (state_d == STOP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= Rx;
      rx_s_q     <= sync_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
      busy_q     <= busy_d;
    end
  end

  // Only four LEDs for the state: PARITY shows as DATA and BREAK shows as STOP.
  always_comb begin
    state_led = 4'b0000;
    case (state_q)
      IDLE:          state_led = 4'b0001;
      START:         state_led = 4'b0010;
      DATA, PARITY:  state_led = 4'b0100;
      STOP, BREAK:   state_led = 4'b1000;
      default:       state_led = 4'b0000;
    endcase
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_busy       = busy_q;
  assign framing_error = ferr_q;
  assign parity_error  = perr_q;
  assign led_debug     = {1'b0, bit_idx_q, rx_data_q, state_led};

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx: directed and random frames, scoreboard-checked by a separate monitor.
// Expected strobe kind, data and arrival cycle are derived from the frame contents and bit timing.
module tb_uart_byte_rx;

  localparam int BIT     = 16;
  localparam int HALF    = BIT / 2;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int BITS_BEFORE_STOP = 10;
`else
  localparam int BITS_BEFORE_STOP = 9;
`endif
  // Two synchronizer flops plus the edge-detect register, then half a bit and the whole frame.
  localparam int LATENCY = 3 + HALF + BITS_BEFORE_STOP * BIT;

  typedef enum int {EV_VALID = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    longint      cyc;
  } ev_t;

  ev_t exp_q[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        framing_error;
  logic        parity_error;
  logic [15:0] led_debug;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  uart_byte_rx #(.BIT_PERIOD(BIT), .HALF_PERIOD(HALF), .PARITY_ODD(PAR_ODD)) dut (
    .clk(clk), .reset_n(reset_n), .Rx(Rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .framing_error(framing_error), .parity_error(parity_error),
    .led_debug(led_debug)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: act=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: act=%0d (0x%0h) req=%0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return (^d) ^ PAR_ODD;
  endfunction

  // Drives one bit for a full bit period; caller is aligned just after a rising edge.
  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    Rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    ev_t e;
    e.data = d;
    e.cyc  = cyc + LATENCY;
    if (!stop_bit) e.kind = EV_FERR;
`ifdef UART_RX_PARITY_EN
    else if (par_bit != good_parity(d)) e.kind = EV_PERR;
`endif
    else e.kind = EV_VALID;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) Rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  // Monitor: every strobe pops one expected event and is checked against it.
  logic [7:0] last_good = 8'h00;
  always @(negedge clk) begin : monitor
    ev_t e;
    int  n;
    ev_kind_t k;
    if (!reset_n) begin
      last_good = 8'h00;
    end else if (rx_valid || framing_error || parity_error) begin
      n = int'(rx_valid) + int'(framing_error) + int'(parity_error);
      check_output("strobe_exclusive", n, 1);
      if (exp_q.size() == 0) begin
        check_output("unexpected_strobe", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        k = rx_valid ? EV_VALID : (framing_error ? EV_FERR : EV_PERR);
        check_output("strobe_kind", int'(k), int'(e.kind));
        check_output("strobe_cycle", cyc, e.cyc);
        if (e.kind == EV_VALID) begin
          check_output("rx_data", rx_data, e.data);
          last_good = e.data;
        end else begin
          check_output("rx_data_held", rx_data, last_good);
        end
      end
    end
  end

  initial begin : stim
    int busy_cycles;
    logic [7:0] d;
    logic stop_bit, par_bit;

    $display("[TB] start, BIT_PERIOD=%0d", BIT);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(100);
    check_output("reset_rx_valid", rx_valid, 0);
    check_output("reset_framing_error", framing_error, 0);
    check_output("reset_parity_error", parity_error, 0);
    check_output("reset_rx_busy", rx_busy, 0);
    check_output("reset_rx_data", rx_data, 8'h00);
    check_output("reset_led_state", led_debug[3:0], 4'b0001);

    apply_stimulus(8'h0A, 1'b1, good_parity(8'h0A));
    idle_cycles(BIT);
    check_output("after_0A_led_data", led_debug[11:4], 8'h0A);

    // Start-bit glitch: 3 cycles low must be rejected at the half-bit sample.
    Rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Rx = 1'b1;
    busy_cycles = 0;
    repeat (30) begin
      @(negedge clk);
      if (rx_busy) busy_cycles++;
    end
    check_output("glitch_busy_bounded", (busy_cycles > 0 && busy_cycles <= HALF) ? 1 : 0, 1);
    check_output("glitch_back_idle", led_debug[3:0], 4'b0001);
    @(posedge clk);
    #1;

    apply_stimulus(8'hA5, 1'b0, good_parity(8'hA5));
    Rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_output("break_held_state", led_debug[3:0], 4'b1000);
    check_output("break_not_busy", rx_busy, 0);
    check_output("break_data_held", rx_data, 8'h0A);
    idle_cycles(BIT);
    check_output("break_released_idle", led_debug[3:0], 4'b0001);
    apply_stimulus(8'h3C, 1'b1, good_parity(8'h3C));
    idle_cycles(BIT);

    apply_stimulus(8'h55, 1'b1, good_parity(8'h55));
    apply_stimulus(8'hFF, 1'b1, good_parity(8'hFF));
    idle_cycles(BIT);

`ifdef UART_RX_PARITY_EN
    apply_stimulus(8'h07, 1'b1, 1'b1);
    idle_cycles(BIT);
    apply_stimulus(8'h07, 1'b1, 1'b0);
    idle_cycles(BIT);
`endif

    // Reset in the middle of the data bits: abort at once, no strobe afterwards.
    Rx = 1'b0;
    repeat (HALF + 3 * BIT) @(posedge clk);
    #1;
    check_output("midframe_busy_before_reset", rx_busy, 1);
    reset_n = 1'b0;
    #1;
    check_output("midframe_reset_busy", rx_busy, 0);
    check_output("midframe_reset_state", led_debug[3:0], 4'b0001);
    check_output("midframe_reset_data", rx_data, 8'h00);
    Rx = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(8 * BIT);
    check_output("after_abort_idle", led_debug[3:0], 4'b0001);

    for (int f = 0; f < 25; f++) begin
      d        = 8'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      par_bit  = ($urandom_range(0, 3) != 0) ? good_parity(d) : ~good_parity(d);
      apply_stimulus(d, stop_bit, par_bit);
      if (!stop_bit) begin
        Rx = 1'b0;
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
        idle_cycles(BIT);
      end else begin
        idle_cycles($urandom_range(0, 20));
      end
    end

    for (int w = 0; w < 1000 && exp_q.size() != 0; w++) @(posedge clk);
    idle_cycles(4);
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART receiver: recovers 8N1 bytes from an asynchronous serial line driven by the team's UART transmitter.
- Mid-bit sampling with start-bit glitch rejection; framing error detection.
- Presents each received byte with a one-cycle valid strobe for downstream consumers (display/VGA text path, debug LEDs).
- Sits between the board Rx pin and the byte-consuming logic.

Parameters:
- BIT_PERIOD, 10417: clk cycles per bit (100 MHz / 9600 baud); legal range 4 or more.
- HALF_PERIOD, BIT_PERIOD/2: cycles from the detected start edge to the start-bit verification sample.
- PARITY_ODD, 0: parity sense used only when UART_RX_PARITY_EN is defined; 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- Rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last good byte received, LSB-first on the line.
- rx_valid  output  1  one-cycle strobe; rx_data is new and valid.
- rx_busy  output  1  high from start-edge detection until the frame ends.
- framing_error  output  1  one-cycle strobe; stop bit sampled low.
- parity_error  output  1  one-cycle strobe; parity mismatch (tied 0 without the macro).
- led_debug  output  16  [3:0] one-hot state, [11:4] rx_data, [15:12] bit_index.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rx_data=8'h00.
  - rx_valid, framing_error, parity_error, rx_busy = 0.
  - Counter and bit_index = 0; synchronizer flops preset to 1.
- Input conditioning: Rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Falling-edge detect is prior rx_s=1 and current rx_s=0.
- One bit counter, 0..BIT_PERIOD-1, cleared on every state entry.
- IDLE:
  - rx_busy=0.
  - On a falling edge of rx_s: go to START and clear the counter.
- START:
  - rx_busy=1.
  - When the counter reaches HALF_PERIOD-1, sample rx_s.
  - rx_s=0: go to DATA with bit_index=0.
  - rx_s=1: glitch; return to IDLE with no strobes.
- DATA:
  - Every BIT_PERIOD cycles, sample rx_s into shift register bit [bit_index], LSB first.
  - After bit_index=7 is sampled: go to PARITY if the macro is defined, else STOP.
- STOP:
  - After BIT_PERIOD cycles, sample rx_s.
  - rx_s=1: on the next cycle rx_data <= shift register, rx_valid=1 for exactly one cycle, go to IDLE.
  - rx_s=0: framing_error=1 for one cycle, rx_data unchanged, rx_valid stays 0, go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE.
  - No new frame is accepted while the line is held low.
- Latency: rx_valid rises 1 clk after the stop-bit sample point. That sample point is HALF_PERIOD + 9*BIT_PERIOD cycles after the synchronized start edge.
- rx_valid, framing_error and parity_error are registered, mutually exclusive, and never asserted for more than one cycle.
- Back-to-back frames: a start edge arriving in the cycle IDLE is re-entered is detected; no idle gap between frames is required.
- An Rx change mid-bit between sample points has no effect; only sample points matter.
- reset_n asserted mid-frame: immediate abort to IDLE; the partial byte is discarded and no strobe is issued.
- default/illegal state: go to IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA; one extra bit is sampled BIT_PERIOD after data bit 7.
  - The expected value is XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - On a mismatch, the frame still completes STOP. If the stop bit is good, parity_error pulses instead of rx_valid and rx_data is not updated.
  - A bad stop bit takes precedence: framing_error pulses instead.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_error is constant 0.

Test Plan:
- Reset released, Rx held 1 for 100 cycles -> all strobes 0, rx_busy=0, rx_data=8'h00, led_debug[3:0]=IDLE.
- BIT_PERIOD=16; drive 8N1 byte 8'h0A (start 0, bits 0,1,0,1,0,0,0,0, stop 1) -> exactly one rx_valid pulse, rx_data=8'h0A, 1 clk after the stop sample (8+144 cycles after the synchronized edge).
- Rx low for 3 cycles then high (BIT_PERIOD=16) -> START then back to IDLE; no rx_valid or framing_error; rx_busy high for at most 8 cycles.
- Byte 8'hA5 with stop bit 0, line low for a further 40 cycles, then 8'h3C sent -> framing_error pulse once, rx_data stays at its prior value, state stays BREAK until the line is high, then rx_data=8'h3C with rx_valid.
- Two back-to-back frames 8'h55 then 8'hFF with zero idle gap -> two rx_valid pulses, rx_data=8'h55 then 8'hFF.
- With UART_RX_PARITY_EN defined, PARITY_ODD=0: 8'h07 sent with parity bit 1 -> rx_valid; same byte with parity bit 0 -> parity_error pulse and rx_data unchanged. Also assert reset_n mid-DATA -> immediate IDLE, no strobes.
